// File: rtl/dab_phase_shift_pwm.sv
// Dual-active-bridge phase-shift modulator: one master period counter drives the
// 3-level bridge voltages and the deadtime-protected gates of both full bridges.

module dab_pwm_leg #(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic [DT_W-1:0] dt,
  input  logic [1:0]      des,   // {hi, lo}; 2'b00 = leg off
  output logic [1:0]      gate   // {hi, lo}
);
  logic [1:0]      prev;
  logic [DT_W-1:0] rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= '0;
      rem  <= '0;
      gate <= '0;
    end else if (ce) begin
      prev <= des;
      if (des != prev) begin
        // Switching on from an idle leg or switching off needs no blanking
        if (dt == '0 || prev == 2'b00 || des == 2'b00) begin
          gate <= des;
          rem  <= '0;
        end else begin
          gate <= 2'b00;
          rem  <= dt;
        end
      end else if (rem != '0) begin
        rem <= rem - DT_W'(1);
        if (rem == DT_W'(1)) gate <= des;
      end else begin
        gate <= des;
      end
    end
  end
endmodule

module dab_phase_shift_pwm #(
  parameter int CNT_W    = 19,
  parameter int DT_W     = 8,
  parameter bit SYNC_REQ = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ce,
  input  logic                    enable,
  input  logic                    sync,
  input  logic                    load,
  input  logic [CNT_W-1:0]        half_per,
  input  logic [CNT_W-1:0]        tau1,
  input  logic [CNT_W-1:0]        tau2,
  input  logic signed [CNT_W-1:0] phi,
  input  logic [DT_W-1:0]         dt,
  output logic signed [1:0]       v1,
  output logic signed [1:0]       v2,
  output logic [3:0]              sp,
  output logic [3:0]              ss,
  output logic                    trigger,
  output logic                    running,
  output logic                    param_err
);
  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, RUN, STOP} state_t;
  state_t state, state_nx;

  logic [CNT_W-1:0]        sh_p, sh_t1, sh_t2, p_a, t1_a, t2_a;
  logic signed [CNT_W-1:0] sh_phi, phi_a;
  logic [DT_W-1:0]         sh_dt, dt_a;
  logic                    pending, load_ok, commit, act, gate_en;
  logic signed [CNT_W+1:0] p_in_s, phi_in_s;
  logic [CNT_W:0]          cnt, cnt_nx, cnt_inc, two_p, last;
  logic signed [CNT_W+1:0] phi_s, two_p_s, c2_raw;
  logic [CNT_W+1:0]        c2;
  logic [3:0][1:0]         des, gate;

  // ---- parameter validation and shadow path (runs regardless of ce)
  assign p_in_s   = $signed({2'b00, half_per});
  assign phi_in_s = $signed({{2{phi[CNT_W-1]}}, phi});
  assign load_ok  = (half_per >= CNT_W'(2)) && (tau1 <= half_per) && (tau2 <= half_per) &&
                    (phi_in_s < p_in_s) && (phi_in_s > -p_in_s);

  assign two_p  = {p_a, 1'b0};
  assign last   = two_p - CNT_ONE;
  assign commit = pending && ((state == IDLE) || (ce && cnt == last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_p <= CNT_W'(2); sh_t1 <= '0; sh_t2 <= '0; sh_phi <= '0; sh_dt <= '0;
      p_a  <= CNT_W'(2); t1_a  <= '0; t2_a  <= '0; phi_a  <= '0; dt_a  <= '0;
      pending   <= 1'b0;
      param_err <= 1'b0;
    end else begin
      if (commit) begin
        p_a <= sh_p; t1_a <= sh_t1; t2_a <= sh_t2; phi_a <= sh_phi; dt_a <= sh_dt;
      end
      if (load && load_ok) begin
        sh_p <= half_per; sh_t1 <= tau1; sh_t2 <= tau2; sh_phi <= phi; sh_dt <= dt;
        param_err <= 1'b0;
        pending   <= 1'b1;
      end else begin
        if (load) param_err <= 1'b1;
        if (commit) pending <= 1'b0;
      end
    end
  end

  // ---- sequencing FSM and master counter
  assign cnt_inc = (cnt == last) ? '0 : cnt + CNT_ONE;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (enable) state_nx = ARM;
      end
      ARM: begin
        cnt_nx = '0;
        if (!enable) state_nx = IDLE;
        else if (!SYNC_REQ || sync) state_nx = RUN;
      end
      RUN: begin
        cnt_nx = cnt_inc;
        if (!enable) state_nx = STOP;
      end
      STOP: begin
        cnt_nx = cnt_inc;
        if (enable) state_nx = RUN;
        else if (cnt == last) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ce) begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign running = (state != IDLE);
  assign act     = (state == RUN) || (state == STOP);

  // ---- bridge 2 counter: cnt - phi folded back into [0, 2P-1]
  assign phi_s   = $signed({{2{phi_a[CNT_W-1]}}, phi_a});
  assign two_p_s = $signed({1'b0, two_p});
  assign c2_raw  = $signed({2'b00, cnt}) - phi_s;

  always_comb begin
    c2 = c2_raw;
    if (c2_raw[CNT_W+1])        c2 = c2_raw + two_p_s;
    else if (c2_raw >= two_p_s) c2 = c2_raw - two_p_s;
  end

  function automatic logic signed [1:0] level(input logic [CNT_W+1:0] c,
                                              input logic [CNT_W-1:0] p,
                                              input logic [CNT_W-1:0] tau);
    logic [CNT_W+1:0] pe, te, tp;
    pe = {2'b00, p};
    te = {2'b00, tau};
    tp = {1'b0, p, 1'b0};
    if (c >= pe - te && c < pe) return 2'b01;
    if (c >= tp - te && c < tp) return 2'b11;
    return 2'b00;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= '0;
      v2      <= '0;
      gate_en <= 1'b0;
      trigger <= 1'b0;
    end else begin
      trigger <= (state == RUN) && (cnt == '0) && ce;
      if (ce) begin
        gate_en <= act;
        v1      <= act ? level({1'b0, cnt}, p_a, t1_a) : 2'b00;
        v2      <= act ? level(c2, p_a, t2_a) : 2'b00;
      end
    end
  end

  // ---- gate map: leg A {S1,S2} is high only at +1, leg B {S3,S4} only at -1
  always_comb begin
    des = '0;
    if (gate_en) begin
      des[0] = (v1 == 2'b01) ? 2'b10 : 2'b01;
      des[1] = (v1 == 2'b11) ? 2'b10 : 2'b01;
      des[2] = (v2 == 2'b01) ? 2'b10 : 2'b01;
      des[3] = (v2 == 2'b11) ? 2'b10 : 2'b01;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_leg
    dab_pwm_leg #(.DT_W(DT_W)) u_leg (
      .clk  (clk),
      .rst_n(rst_n),
      .ce   (ce),
      .dt   (dt_a),
      .des  (des[g]),
      .gate (gate[g])
    );
  end

  assign sp = {gate[1][0], gate[1][1], gate[0][0], gate[0][1]};
  assign ss = {gate[3][0], gate[3][1], gate[2][0], gate[2][1]};
endmodule

// File: tb/tb_dab_phase_shift_pwm.sv
// Directed bench for dab_phase_shift_pwm: levels, phase shift, deadtime,
// shadow commit, parameter rejection, stop/freeze/reset sequencing.
module tb_dab_phase_shift_pwm;
  localparam int CNT_W = 19;
  localparam int DT_W  = 8;

  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b1, enable = 1'b0, sync = 1'b0, load = 1'b0;
  logic [CNT_W-1:0]        half_per = '0, tau1 = '0, tau2 = '0;
  logic signed [CNT_W-1:0] phi = '0;
  logic [DT_W-1:0]         dt = '0;
  logic signed [1:0]       v1, v2;
  logic [3:0]              sp, ss;
  logic                    trigger, running, param_err;

  int ncmp = 0, nerr = 0, cyc = 0, idx = 0, cyc0 = 0;
  // Hand table: P=10, tau=4, one entry per count 0..19
  int exp4 [20] = '{0,0,0,0,0,0,1,1,1,1,0,0,0,0,0,0,-1,-1,-1,-1};

  dab_phase_shift_pwm #(.CNT_W(CNT_W), .DT_W(DT_W), .SYNC_REQ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .enable(enable), .sync(sync), .load(load),
    .half_per(half_per), .tau1(tau1), .tau2(tau2), .phi(phi), .dt(dt),
    .v1(v1), .v2(v2), .sp(sp), .ss(ss),
    .trigger(trigger), .running(running), .param_err(param_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gmap(input int lv);
    if (lv == 1)  return 4'b1001;
    if (lv == -1) return 4'b0110;
    return 4'b1010;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    cyc++; idx++;
  endtask

  task automatic goto_idx(input int k);
    while (idx < k) step();
  endtask

  task automatic wait_trig(input string tag, input int lim);
    int k;
    k = 0;
    step();
    while (trigger !== 1'b1 && k < lim) begin step(); k++; end
    ncmp++;
    assert (trigger === 1'b1) else begin
      nerr++;
      $error("FAIL %s: trigger=%b after %0d cycles, expected 1", tag, trigger, lim);
    end
    idx = 0;
  endtask

  task automatic do_load(input int p, input int t1, input int t2, input int ph, input int d);
    half_per = CNT_W'(p); tau1 = CNT_W'(t1); tau2 = CNT_W'(t2);
    phi = CNT_W'(ph); dt = DT_W'(d);
    load = 1'b1; step(); load = 1'b0;
  endtask

  // One P=10/tau=4 period from its trigger; dt=0 so gates trail levels by one cycle
  task automatic period_chk(input string tag, input int sh);
    for (int k = 0; k < 20; k++) begin
      chk({tag, " v1"}, v1, exp4[k]);
      chk({tag, " v2"}, v2, exp4[(k - sh + 20) % 20]);
      chk({tag, " trig"}, trigger, (k == 0) ? 1 : 0);
      if (k >= 1) begin
        chk({tag, " sp"}, sp, gmap(exp4[k-1]));
        chk({tag, " ss"}, ss, gmap(exp4[(k - 1 - sh + 20) % 20]));
      end
      step();
    end
    chk({tag, " trig next"}, trigger, 1);
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1)
      chk("leg hi&lo", {sp[0] & sp[1], sp[2] & sp[3], ss[0] & ss[1], ss[2] & ss[3]}, 0);

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst sp", sp, 0);          chk("rst ss", ss, 0);
    chk("rst v1", v1, 0);          chk("rst v2", v2, 0);
    chk("rst running", running, 0); chk("rst trigger", trigger, 0);
    chk("rst param_err", param_err, 0);
    rst_n = 1'b1;

    // Basic waveform, phi=0
    do_load(10, 4, 4, 0, 0);
    step(); step();
    enable = 1'b1; step();
    chk("arm running", running, 1);
    chk("arm no trig", trigger, 0);
    sync = 1'b1; step(); sync = 1'b0;
    wait_trig("start", 50);
    period_chk("p10", 0);

    do_load(10, 4, 4, 3, 0);
    wait_trig("phi+3", 60);
    period_chk("phi+3", 3);

    do_load(10, 4, 4, -3, 0);
    wait_trig("phi-3", 60);
    period_chk("phi-3", -3);

    // P=500 near-full pulses, bridge 2 wraps through count 0
    do_load(500, 499, 499, -17, 0);
    wait_trig("p500", 3000);
    chk("p500 v1 c0", v1, 0);
    goto_idx(1);   chk("p500 v1 c1", v1, 1);
    goto_idx(982); chk("p500 v2 c999", v2, -1);
    goto_idx(983); chk("p500 v2 c0", v2, 0);
    goto_idx(984); chk("p500 v2 c1", v2, 1);
    goto_idx(995);
    for (int k = 995; k < 1005; k++) begin
      chk("p500 v2 wrap", v2, 1);
      if (k == 999)  chk("p500 v1 c999", v1, -1);
      if (k == 1000) begin chk("p500 trig", trigger, 1); chk("p500 v1 next c0", v1, 0); end
      if (k == 1001) chk("p500 v1 next c1", v1, 1);
      step();
    end

    // Deadtime 2 on P=10, tau=4
    do_load(10, 4, 4, 0, 2);
    wait_trig("dt2", 3000);
    goto_idx(6);  chk("dt A lo", sp[1:0], 2'b10);
    goto_idx(7);  chk("dt A off1", sp[1:0], 2'b00); chk("dt sA off1", ss[1:0], 2'b00);
    goto_idx(8);  chk("dt A off2", sp[1:0], 2'b00);
    goto_idx(9);  chk("dt A hi", sp[1:0], 2'b01);   chk("dt sA hi", ss[1:0], 2'b01);
    goto_idx(10); chk("dt A hi hold", sp[1:0], 2'b01);
    goto_idx(11); chk("dt A off3", sp[1:0], 2'b00);
    goto_idx(13); chk("dt A lo again", sp[1:0], 2'b10);
    goto_idx(16); chk("dt B lo", sp[3:2], 2'b10);
    goto_idx(17); chk("dt B off1", sp[3:2], 2'b00);
    goto_idx(18); chk("dt B off2", sp[3:2], 2'b00);
    goto_idx(19); chk("dt B hi", sp[3:2], 2'b01);

    // Shadow load mid-period takes effect only after the wrap
    wait_trig("tau load", 60);
    goto_idx(7);
    do_load(10, 2, 4, 0, 2);
    goto_idx(16); chk("old tau c16", v1, -1);
    wait_trig("tau2 period", 60);
    goto_idx(6);  chk("new tau c6", v1, 0);
    goto_idx(8);  chk("new tau c8", v1, 1);
    goto_idx(16); chk("new tau c16", v1, 0);
    goto_idx(18); chk("new tau c18", v1, -1);

    // Rejection and recovery of parameter loads
    do_load(10, 11, 4, 0, 2);   chk("err tau>P", param_err, 1);
    do_load(10, 2, 4, 0, 2);    chk("ok clears", param_err, 0);
    do_load(10, 2, 4, -10, 2);  chk("err phi=-P", param_err, 1);
    do_load(10, 2, 4, 0, 2);    chk("ok clears 2", param_err, 0);
    do_load(1, 0, 0, 0, 2);     chk("err P=1", param_err, 1);
    idx = 0;
    goto_idx(2);  chk("kept tau", v1, v1 === 2'sb00 ? 0 : 99);
    wait_trig("kept", 60);
    goto_idx(6);  chk("kept tau c6", v1, 0);
    goto_idx(8);  chk("kept tau c8", v1, 1);
    do_load(10, 10, 4, 0, 2);   chk("ok tau=P", param_err, 0);
    wait_trig("tauP", 60);
    chk("tauP c0", v1, 1);
    goto_idx(9);  chk("tauP c9", v1, 1);
    goto_idx(10); chk("tauP c10", v1, -1);
    goto_idx(19); chk("tauP c19", v1, -1);

    // Stop request mid-period runs to the end of the period
    wait_trig("stop", 60);
    goto_idx(4); enable = 1'b0;
    goto_idx(18); chk("stop running", running, 1);
    goto_idx(19); chk("stop idle", running, 0); chk("stop v1 c19", v1, -1);
    goto_idx(20); chk("stop v1 off", v1, 0); chk("stop no trig", trigger, 0);
    goto_idx(21); chk("stop sp off", sp, 0); chk("stop ss off", ss, 0);

    // Clock-enable freeze
    enable = 1'b1; step();
    sync = 1'b1; step(); sync = 1'b0;
    wait_trig("restart", 50);
    cyc0 = cyc;
    goto_idx(8); chk("pre-freeze v1", v1, 1); chk("pre-freeze sp", sp, 4'b1001);
    ce = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("frozen v1", v1, 1);
      chk("frozen sp", sp, 4'b1001);
      chk("frozen trig", trigger, 0);
    end
    ce = 1'b1;
    step(); chk("thaw v1 c9", v1, 1);
    step(); chk("thaw v1 c10", v1, -1);
    wait_trig("post-freeze", 60);
    chk("freeze period len", cyc - cyc0, 25);

    // Asynchronous reset mid-run
    goto_idx(3); chk("pre-rst sp", sp, 4'b1001);
    rst_n = 1'b0; #1;
    chk("arst sp", sp, 0);  chk("arst ss", ss, 0);
    chk("arst v1", v1, 0);  chk("arst v2", v2, 0);
    chk("arst running", running, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
